// File: rtl/bcd_xs3_serial_codec.sv
// Bit-serial BCD <-> Excess-3 converter for a packed word of DIGITS nibbles.
// One full adder is reused for every bit, LSB first. Each digit is handled
// modulo 16, and no carry passes from one digit into the next.
module bcd_xs3_serial_codec #(
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_mode,
    input  logic [4*DIGITS-1:0]   in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DIGITS-1:0]   out_data,
    output logic [DIGITS-1:0]     out_err
);

    localparam int W  = 4 * DIGITS;
    localparam int CW = $clog2(W);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [W-1:0]      src_reg;
    logic [W-1:0]      res_reg;
    logic [CW-1:0]     cnt;
    logic              cy;
    logic              mode_reg;
    logic [DIGITS-1:0] err_reg;
    logic [DIGITS-1:0] err_mask;
    logic [3:0]        digit;
    logic [1:0]        k;
    logic              a_bit;
    logic              c_bit;
    logic              cy_in;
    logic              sum_bit;
    logic              cy_next;
    logic              last_bit;

    // Flag illegal digits of the word on the input port, so the mask is ready at accept
    always_comb begin
        err_mask = '0;
        digit    = '0;
        for (int i = 0; i < DIGITS; i++) begin
            digit = in_data[4*i +: 4];
            if (in_mode)
                err_mask[i] = (digit < 4'd3) || (digit > 4'd12);
            else
                err_mask[i] = (digit > 4'd9);
        end
    end

    // One serial full-adder step: add 0011, or add 1100 plus 1 (= -3 mod 16)
    always_comb begin
        k        = cnt[1:0];
        a_bit    = src_reg[0];
        c_bit    = mode_reg ? k[1] : ~k[1];
        cy_in    = (k == 2'd0) ? mode_reg : cy;
        sum_bit  = a_bit ^ c_bit ^ cy_in;
        cy_next  = (a_bit & c_bit) | (a_bit & cy_in) | (c_bit & cy_in);
        last_bit = (cnt == CW'(W - 1));
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_next;
    end

    // Next-state logic for the IDLE -> SHIFT -> DONE handshake sequence
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid) state_next = SHIFT;
            SHIFT:   if (last_bit) state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath: load on accept, then shift one bit per clock into the result MSB
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            src_reg  <= '0;
            res_reg  <= '0;
            cnt      <= '0;
            cy       <= 1'b0;
            mode_reg <= 1'b0;
            err_reg  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        src_reg  <= in_data;
                        mode_reg <= in_mode;
                        err_reg  <= err_mask;
                        cnt      <= '0;
                        cy       <= 1'b0;
                    end
                end
                SHIFT: begin
                    src_reg <= src_reg >> 1;
                    res_reg <= {sum_bit, res_reg[W-1:1]};
                    cy      <= cy_next;
                    cnt     <= cnt + CW'(1);
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign out_data  = res_reg;
    assign out_err   = err_reg;

endmodule

// File: tb/tb_bcd_xs3_serial_codec.sv
// Self-checking bench for bcd_xs3_serial_codec: a 4-digit instance checked every
// cycle against a per-digit arithmetic model, plus a 1-digit instance swept exhaustively.
module tb_bcd_xs3_serial_codec;

    localparam int DIGITS = 4;
    localparam int W      = 4 * DIGITS;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        in_mode = 1'b0;
    logic [15:0] in_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_data;
    logic [3:0]  out_err;

    logic        v1 = 1'b0;
    logic        r1;
    logic        m1 = 1'b0;
    logic [3:0]  d1 = '0;
    logic        ov1;
    logic        or1 = 1'b0;
    logic [3:0]  od1;
    logic [0:0]  oe1;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 0;

    int          m_phase = 0;
    int          m_left  = 0;
    logic [15:0] m_data  = '0;
    logic [3:0]  m_err   = '0;
    bit          m_zero  = 1;

    always #5 clk = ~clk;

    bcd_xs3_serial_codec #(.DIGITS(DIGITS)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_err(out_err)
    );

    bcd_xs3_serial_codec #(.DIGITS(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(v1), .in_ready(r1), .in_mode(m1), .in_data(d1),
        .out_valid(ov1), .out_ready(or1), .out_data(od1), .out_err(oe1)
    );

    // Reference conversion: each digit plus 3 or minus 3, modulo 16
    function automatic logic [15:0] ref_conv(input logic [15:0] d, input logic m, input int nd);
        logic [15:0] r;
        int v;
        r = '0;
        for (int i = 0; i < nd; i++) begin
            v = int'(d[4*i +: 4]);
            v = m ? (v + 13) % 16 : (v + 3) % 16;
            r[4*i +: 4] = 4'(v);
        end
        return r;
    endfunction

    // Reference illegal-digit mask
    function automatic logic [3:0] ref_err(input logic [15:0] d, input logic m, input int nd);
        logic [3:0] e;
        int v;
        e = '0;
        for (int i = 0; i < nd; i++) begin
            v = int'(d[4*i +: 4]);
            e[i] = m ? ((v < 3) || (v > 12)) : (v > 9);
        end
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: a word is busy for W edges after acceptance, then held
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase = 0;
            m_left  = 0;
            m_data  = '0;
            m_err   = '0;
            m_zero  = 1;
        end else begin
            case (m_phase)
                0: if (in_valid) begin
                    m_phase = 1;
                    m_left  = W;
                    m_data  = ref_conv(in_data, in_mode, DIGITS);
                    m_err   = ref_err(in_data, in_mode, DIGITS);
                    m_zero  = 0;
                end
                1: begin
                    m_left--;
                    if (m_left == 0) m_phase = 2;
                end
                default: if (out_ready) m_phase = 0;
            endcase
        end
    end

    // Per-cycle comparison of the 4-digit instance against the model
    always @(negedge clk) begin
        if (chk_en) begin
            check("in_ready", 32'(in_ready), 32'(m_phase == 0));
            check("out_valid", 32'(out_valid), 32'(m_phase == 2));
            if (m_phase == 2 || m_zero) begin
                check("out_data", 32'(out_data), 32'(m_data));
                check("out_err", 32'(out_err), 32'(m_err));
            end
        end
    end

    // Offer a word and hold it until the accepting edge has passed
    task automatic applyStimulus(input logic [15:0] d, input logic m);
        int t;
        in_data  = d;
        in_mode  = m;
        in_valid = 1'b1;
        t = 0;
        while (!in_ready && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        check("accept_wait", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_data  = 16'($urandom);
        in_mode  = 1'($urandom_range(0, 1));
    endtask

    task automatic waitResult();
        int lat;
        lat = 0;
        while (lat < 64) begin
            @(negedge clk);
            if (out_valid) break;
            lat++;
        end
        check("latency", 32'(lat), 32'(W));
    endtask

    task automatic checkOutput(input string tag, input logic [15:0] ed, input logic [3:0] ee);
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_data"}, 32'(out_data), 32'(ed));
        check({tag, "_err"}, 32'(out_err), 32'(ee));
    endtask

    task automatic releaseResult();
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    logic [15:0] vec_in  [5] = '{16'h1234, 16'h4567, 16'h9999, 16'h9A05, 16'h0013};
    logic        vec_md  [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    logic [15:0] vec_out [5] = '{16'h4567, 16'h1234, 16'hCCCC, 16'hCD38, 16'hDDE0};
    logic [3:0]  vec_err [5] = '{4'b0000, 4'b0000, 4'b0000, 4'b0100, 4'b1110};

    initial begin
        logic [15:0] ref_w;
        logic [3:0]  ref_e;
        int          lat;

        check("pin_conv_9A05", 32'(ref_conv(16'h9A05, 1'b0, 4)), 32'h0000CD38);
        check("pin_err_0013", 32'(ref_err(16'h0013, 1'b1, 4)), 32'h0000000E);
        check("pin_conv_0808", 32'(ref_conv(16'h0808, 1'b0, 4)), 32'h00003B3B);

        @(posedge clk); #1;
        chk_en = 1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        $display("[TB] directed vectors");
        for (int i = 0; i < 5; i++) begin
            applyStimulus(vec_in[i], vec_md[i]);
            waitResult();
            checkOutput("vec", vec_out[i], vec_err[i]);
            releaseResult();
        end

        $display("[TB] backpressure");
        applyStimulus(16'h2468, 1'b0);
        waitResult();
        checkOutput("bp_first", 16'h579B, 4'b0000);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            in_valid = 1'b1;
            in_data  = 16'($urandom);
            in_mode  = 1'($urandom_range(0, 1));
            @(negedge clk);
            check("bp_in_ready", 32'(in_ready), 32'd0);
            check("bp_hold", 32'(out_data), 32'h0000579B);
        end
        in_valid = 1'b0;
        releaseResult();
        applyStimulus(16'h0000, 1'b0);
        waitResult();
        checkOutput("bp_next", 16'h3333, 4'b0000);
        releaseResult();

        $display("[TB] reset during conversion");
        applyStimulus(16'h7777, 1'b1);
        repeat (6) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_out_err", 32'(out_err), 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        applyStimulus(16'h0808, 1'b0);
        waitResult();
        checkOutput("rst_restart", 16'h3B3B, 4'b0000);
        releaseResult();

        $display("[TB] randomized traffic");
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #1;
            if (!rst_n) rst_n = 1'b1;
            else if ($urandom_range(0, 255) == 0) rst_n = 1'b0;
            in_valid  = 1'($urandom_range(0, 1));
            in_data   = 16'($urandom);
            in_mode   = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 3) != 0);
        end
        @(posedge clk); #1;
        rst_n     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (30) @(posedge clk);
        #1 out_ready = 1'b0;

        $display("[TB] single-digit sweep");
        for (int m = 0; m < 2; m++) begin
            for (int d = 0; d < 16; d++) begin
                @(posedge clk); #1;
                check("d1_ready", 32'(r1), 32'd1);
                m1 = 1'(m);
                d1 = 4'(d);
                v1 = 1'b1;
                @(posedge clk); #1;
                v1 = 1'b0;
                lat = 0;
                while (lat < 32) begin
                    @(negedge clk);
                    if (ov1) break;
                    lat++;
                end
                ref_w = ref_conv(16'(d), 1'(m), 1);
                ref_e = ref_err(16'(d), 1'(m), 1);
                check("d1_latency", 32'(lat), 32'd4);
                check("d1_data", 32'(od1), 32'(ref_w[3:0]));
                check("d1_err", 32'(oe1), 32'(ref_e[0]));
                @(posedge clk); #1 or1 = 1'b1;
                @(posedge clk); #1 or1 = 1'b0;
            end
        end

        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
